bcd_cascade_counter: RTL and testbench
======================================

Name: bcd_cascade_counter

Overview:
- Parametrised multi-digit BCD counter; successor to the single-digit decade counter.
- Cascades NUM_DIGITS decimal digits, each modulo MODULUS, with up/down counting, synchronous parallel load, terminal-count flag and wrap pulse.
- Used as an event or timestamp counter feeding display and timer logic; single clock domain.

Parameters:
- NUM_DIGITS, 4, number of cascaded digits (1..8); count width is 4*NUM_DIGITS.
- MODULUS, 10, per-digit modulus (2..10); each digit ranges 0..MODULUS-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  count enable; the counter advances one step per clk edge while high.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  4*NUM_DIGITS  load value, digit 0 in bits [3:0].
- count  out  4*NUM_DIGITS  current value, BCD, digit 0 least significant.
- tc  out  1  terminal count, combinational.
- wrap  out  1  registered one-cycle wrap pulse.
- ovf  out  1  sticky overflow flag; see Optional Feature.

Behaviour:
- All state updates on posedge clk. Priority: rst > load > en.
- Reset: count=0, wrap=0, ovf=0. Reset applied mid-count overrides load and en on the same edge.
- Load: each digit takes its load_val nibble. A nibble greater than MODULUS-1 clamps to MODULUS-1. wrap=0 on the load cycle. Load ignores en.
- Count with en=1 and up_dn=1:
  - digit 0 increments every edge.
  - digit k increments when all lower digits equal MODULUS-1.
  - a digit at MODULUS-1 that increments returns to 0.
- Count with en=1 and up_dn=0:
  - digit 0 decrements every edge.
  - digit k decrements when all lower digits equal 0.
  - a digit at 0 that decrements goes to MODULUS-1.
- Hold: with en=0 and no load, count holds; wrap=0 on the next edge.
- tc (combinational from count and up_dn, independent of en):
  - up: 1 when every digit equals MODULUS-1.
  - down: 1 when every digit equals 0.
  - tc follows a direction change immediately.
- wrap: registered; 1 for exactly one cycle, coincident with the wrapped count value.
  - up wrap: all-max to all-zero. Down wrap: all-zero to all-max.
  - Requires en=1, tc=1 and no load or rst on that edge.
  - Continuous counting with NUM_DIGITS=1, MODULUS=2 gives a wrap pulse every 2 cycles.
- Latency: count changes one edge after load or en is sampled; wrap is valid in the same cycle as the new count.
- Direction may change on any cycle; the step on the next edge uses the sampled up_dn.
- Internal digit values never exceed MODULUS-1.

Optional Feature:
- Macro: BCD_CASCADE_OVF_STICKY_EN.
- Defined:
  - ovf is a register set on any edge where wrap is set.
  - Cleared only by rst or load.
  - If set and clear occur together, the clear wins.
- Undefined: ovf port is present and tied to 0; no register is inferred.

Decomposition:
- Shared package bcd_cascade_pkg:
  - localparam DIGIT_W=4.
  - typedef digit_t (logic [3:0]).
  - function clamp_digit(val, modulus).
- Sub-module bcd_digit_cell, one per digit, generated NUM_DIGITS times:
  - Inputs: clk, rst, load, load_digit, step, up_dn.
  - Outputs: digit, at_max, at_zero.
  - Carry/borrow chain, tc and wrap logic live in the top level.

Test Plan (NUM_DIGITS=3, MODULUS=10 unless stated):
- Reset: hold rst=1 with load=1, en=1 for 2 edges -> count=000, wrap=0, ovf=0; with up_dn=1, tc=0.
- Up wrap: load 998, then en=1, up_dn=1 for 2 edges -> 999 with tc=1, then 000 with wrap=1 for one cycle; next edge 001, wrap=0. With the macro defined, ovf=1 and stays 1.
- Down and borrow: load 100, en=1, up_dn=0 for 1 edge -> 099. Load 000 and step down once -> 999 with wrap=1; tc was 1 before the step.
- Hold and priority: at 042, en=0 for 5 edges -> count stays 042, wrap=0. Then load=1 with load_val=500 and en=1 -> 500; ovf clears.
- Clamp: load_val=0x0AF -> count=099. The checker asserts on every edge that no digit exceeds 9.
- Small modulus: NUM_DIGITS=2, MODULUS=6, up from 00 for 36 edges -> returns to 00 with a single wrap pulse; tc=1 exactly at 55.

Source files
------------

// File: rtl/bcd_cascade_pkg.sv
// rtl/bcd_cascade_pkg.sv - shared digit type, width and clamp helper for the BCD cascade counter
package bcd_cascade_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Out-of-range load nibbles saturate to the top legal digit value.
  function automatic digit_t clamp_digit(input digit_t val, input int modulus);
    digit_t max_v;
    max_v = digit_t'(modulus - 1);
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one modulo-MODULUS decimal digit with load and up/down step
module bcd_digit_cell
  import bcd_cascade_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  digit_t load_digit,
  input  logic   step,
  input  logic   up_dn,
  output digit_t digit,
  output logic   at_max,
  output logic   at_zero
);

  localparam digit_t MAX_D = digit_t'(MODULUS - 1);

  assign at_max  = (digit == MAX_D);
  assign at_zero = (digit == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp_digit(load_digit, MODULUS);
    end else if (step) begin
      if (up_dn) begin
        digit <= at_max ? '0 : digit + digit_t'(1);
      end else begin
        digit <= at_zero ? MAX_D : digit - digit_t'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// rtl/bcd_cascade_counter.sv - cascaded up/down BCD counter; BCD_CASCADE_OVF_STICKY_EN enables sticky ovf
module bcd_cascade_counter
  import bcd_cascade_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MODULUS    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          tc,
  output logic                          wrap,
  output logic                          ovf
);

  digit_t                digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_zero;
  logic [NUM_DIGITS-1:0] step;
  logic                  chain_max;
  logic                  chain_zero;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_cell #(
      .MODULUS(MODULUS)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_digit(load_val[k*DIGIT_W +: DIGIT_W]),
      .step      (step[k]),
      .up_dn     (up_dn),
      .digit     (digits[k]),
      .at_max    (at_max[k]),
      .at_zero   (at_zero[k])
    );
    assign count[k*DIGIT_W +: DIGIT_W] = digits[k];
  end

  // Ripple carry/borrow: a digit moves only when every lower digit is at its turnover value.
  always_comb begin
    step       = '0;
    chain_max  = 1'b1;
    chain_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      step[k]    = en & (up_dn ? chain_max : chain_zero);
      chain_max  = chain_max & at_max[k];
      chain_zero = chain_zero & at_zero[k];
    end
    tc = up_dn ? chain_max : chain_zero;
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      wrap <= 1'b0;
    end else begin
      wrap <= en & tc;
    end
  end

`ifdef BCD_CASCADE_OVF_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst || load) begin
      ovf <= 1'b0;
    end else if (en && tc) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb/tb_bcd_cascade_counter.sv - scoreboard bench for bcd_cascade_counter (3x10 and 2x6 instances)
module tb_bcd_cascade_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, load = 1'b0, en = 1'b0, up_dn = 1'b1;
  logic [11:0] load_val = '0;
  logic [11:0] count;
  logic        tc, wrap, ovf;

  logic        s_rst = 1'b1, s_load = 1'b0, s_en = 1'b0, s_up_dn = 1'b1;
  logic [7:0]  s_load_val = '0;
  logic [7:0]  s_count;
  logic        s_tc, s_wrap, s_ovf;

  bcd_cascade_counter #(.NUM_DIGITS(3), .MODULUS(10)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  bcd_cascade_counter #(.NUM_DIGITS(2), .MODULUS(6)) u_small (
    .clk(clk), .rst(s_rst), .en(s_en), .up_dn(s_up_dn), .load(s_load), .load_val(s_load_val),
    .count(s_count), .tc(s_tc), .wrap(s_wrap), .ovf(s_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] count;
    logic        wrap;
    logic        tc;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t q_main[$];
  exp_t q_small[$];

  function automatic logic ov(input logic v);
`ifdef BCD_CASCADE_OVF_STICKY_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string nm, input string field, input logic [11:0] got, input logic [11:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %0h required %0h at %0t", nm, field, got, req, $time);
    end
  endtask

  task automatic bound(input string nm, input logic [3:0] d, input logic [3:0] lim);
    n_checks++;
    if (!(d <= lim)) begin
      n_fail++;
      $display("FAIL %s digit_bound: got %0h required <= %0h at %0t", nm, d, lim, $time);
    end
  endtask

  task automatic drv(input logic r, input logic l, input logic [11:0] lv, input logic e, input logic ud,
                     input logic [11:0] ec, input logic ew, input logic et, input logic eo, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; load_val = lv; en = e; up_dn = ud;
    x.count = ec; x.wrap = ew; x.tc = et; x.ovf = ov(eo); x.name = nm;
    q_main.push_back(x);
  endtask

  task automatic drv_small(input logic r, input logic e, input logic [7:0] ec,
                           input logic ew, input logic et, input logic eo, input string nm);
    exp_t x;
    @(negedge clk);
    s_rst = r; s_en = e; s_up_dn = 1'b1;
    x.count = {4'h0, ec}; x.wrap = ew; x.tc = et; x.ovf = ov(eo); x.name = nm;
    q_small.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int k = 0; k < 3; k++) bound("main", count[k*4 +: 4], 4'd9);
    if (q_main.size() > 0) begin
      e = q_main.pop_front();
      check(e.name, "count", count, e.count);
      check(e.name, "wrap", {11'h0, wrap}, {11'h0, e.wrap});
      check(e.name, "tc", {11'h0, tc}, {11'h0, e.tc});
      check(e.name, "ovf", {11'h0, ovf}, {11'h0, e.ovf});
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int k = 0; k < 2; k++) bound("small", s_count[k*4 +: 4], 4'd5);
    if (q_small.size() > 0) begin
      e = q_small.pop_front();
      check(e.name, "count", {4'h0, s_count}, e.count);
      check(e.name, "wrap", {11'h0, s_wrap}, {11'h0, e.wrap});
      check(e.name, "tc", {11'h0, s_tc}, {11'h0, e.tc});
      check(e.name, "ovf", {11'h0, s_ovf}, {11'h0, e.ovf});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //  rst load load_val  en ud  count   wrap tc ovf
    drv(1, 1, 12'h123, 1, 1, 12'h000, 0, 0, 0, "reset_1");
    drv(1, 1, 12'h123, 1, 1, 12'h000, 0, 0, 0, "reset_2");
    drv(0, 1, 12'h998, 0, 1, 12'h998, 0, 0, 0, "load_998");
    drv(0, 0, 12'h000, 1, 1, 12'h999, 0, 1, 0, "up_999");
    drv(0, 0, 12'h000, 1, 1, 12'h000, 1, 0, 1, "up_wrap");
    drv(0, 0, 12'h000, 1, 1, 12'h001, 0, 0, 1, "up_after_wrap");
    drv(0, 0, 12'h000, 0, 1, 12'h001, 0, 0, 1, "hold_ovf_sticky");
    drv(0, 1, 12'h100, 0, 0, 12'h100, 0, 0, 0, "load_100");
    drv(0, 0, 12'h000, 1, 0, 12'h099, 0, 0, 0, "down_borrow");
    drv(0, 1, 12'h000, 0, 0, 12'h000, 0, 1, 0, "load_000_tc");
    drv(0, 0, 12'h000, 1, 0, 12'h999, 1, 0, 1, "down_wrap");
    drv(0, 0, 12'h000, 0, 1, 12'h999, 0, 1, 1, "dir_change_tc");
    drv(0, 0, 12'h000, 1, 1, 12'h000, 1, 0, 1, "up_wrap_again");
    for (int i = 1; i <= 42; i++) drv(0, 0, 12'h000, 1, 1, to_bcd(i), 0, 0, 1, "up_to_042");
    repeat (5) drv(0, 0, 12'h000, 0, 1, 12'h042, 0, 0, 1, "hold_042");
    drv(0, 1, 12'h500, 1, 1, 12'h500, 0, 0, 0, "load_over_en");
    drv(0, 1, 12'h0AF, 0, 1, 12'h099, 0, 0, 0, "clamp_0AF");
    drv(1, 1, 12'h777, 1, 1, 12'h000, 0, 0, 0, "reset_mid");
    drv(0, 0, 12'h000, 1, 0, 12'h999, 1, 0, 1, "down_wrap_2");
    drv(1, 0, 12'h000, 1, 0, 12'h000, 0, 1, 0, "reset_clears_ovf");

    drv_small(1, 0, 8'h00, 0, 0, 0, "small_reset");
    for (int i = 1; i <= 36; i++) begin
      int v;
      v = i % 36;
      drv_small(0, 1, {4'(v / 6), 4'(v % 6)}, (i == 36), (v == 35), (i == 36), "small_up");
    end

    repeat (3) @(negedge clk);
    check("drain", "main_queue", 12'(q_main.size()), 12'h000);
    check("drain", "small_queue", 12'(q_small.size()), 12'h000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
